// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the core and the iterative RV32M
// multiply/divide unit. The core side uses the master modport and the unit
// uses the slave modport.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            out_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            in_flush;
  logic            out_valid;
  logic            in_result_ready;
  logic [XLEN-1:0] out_result;
  logic            out_busy;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_flush, in_result_ready,
    input  out_ready, out_valid, out_result, out_busy
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_flush, in_result_ready,
    output out_ready, out_valid, out_result, out_busy
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit. One op is accepted in IDLE, operands
// are reduced to magnitudes in PREP, a shift-add multiply or restoring divide
// runs one bit per cycle in CALC, and FIXUP applies the sign and the ISA
// corner cases before the result is held in DONE until taken.
// Optional feature: define MULDIV_EARLY_OUT_EN to skip the iterations when
// rs2 is zero (any op) or rs1 is zero (multiply).
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int AW = 2 * XLEN + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_CALC  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;     // raw rs1, kept for the REM-by-zero result
  logic [XLEN-1:0] op_b;     // rs2, replaced by its magnitude in PREP
  logic            res_neg;
  logic [AW-1:0]   acc;      // mul: {carry, hi, lo}; div: {remainder, quotient}
  logic [CW-1:0]   count;
  logic [XLEN-1:0] result;

  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic            sign_next;
  logic            b_zero;
  logic            early_out;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_next;
  logic [AW-1:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic [AW-1:0]   div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_result;

  // Which operands are interpreted as signed for the latched funct3.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010: begin
        a_signed = 1'b1;
        b_signed = 1'b0;
      end
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
  end

  assign is_div    = funct3[2];
  assign a_neg     = a_signed & op_a[XLEN-1];
  assign b_neg     = b_signed & op_b[XLEN-1];
  assign abs_a     = a_neg ? ({XLEN{1'b0}} - op_a) : op_a;
  assign abs_b     = b_neg ? ({XLEN{1'b0}} - op_b) : op_b;
  // Remainder takes the dividend's sign; everything else takes sA^sB.
  assign sign_next = (is_div & funct3[1]) ? a_neg : (a_neg ^ b_neg);
  assign b_zero    = (op_b == {XLEN{1'b0}});

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = (op_b == {XLEN{1'b0}}) | (~is_div & (op_a == {XLEN{1'b0}}));
`else
  assign early_out = 1'b0;
`endif

  // Shift-add multiply step: add B when the multiplier LSB is set, shift right.
  assign mul_sum  = acc[AW-1:XLEN] + ({1'b0, op_b} & {(XLEN+1){acc[0]}});
  assign mul_next = {1'b0, mul_sum, acc[XLEN-1:1]};

  // Restoring divide step: shift left, trial subtract with one guard bit.
  assign div_shift = {acc[AW-2:0], 1'b0};
  assign div_diff  = {1'b0, div_shift[AW-1:XLEN]} - {2'b00, op_b};
  assign div_next  = div_diff[XLEN+1] ? div_shift
                                      : {div_diff[XLEN:0], div_shift[XLEN-1:1], 1'b1};

  assign prod_fix = res_neg ? ({(2*XLEN){1'b0}} - acc[2*XLEN-1:0]) : acc[2*XLEN-1:0];
  assign quot_fix = res_neg ? ({XLEN{1'b0}} - acc[XLEN-1:0]) : acc[XLEN-1:0];
  assign rem_fix  = res_neg ? ({XLEN{1'b0}} - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];

  // Final result selection including the divide-by-zero results.
  always_comb begin
    fix_result = {XLEN{1'b0}};
    case (funct3)
      3'b000:                 fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (b_zero) begin
          fix_result = {XLEN{1'b1}};
        end else begin
          fix_result = quot_fix;
        end
      end
      3'b110, 3'b111: begin
        if (b_zero) begin
          fix_result = op_a;
        end else begin
          fix_result = rem_fix;
        end
      end
      default: fix_result = {XLEN{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a flush returns to IDLE from any state.
  always_comb begin
    next_state = state;
    if (bus.in_flush) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            next_state = ST_PREP;
          end else begin
            next_state = ST_IDLE;
          end
        end
        // Early-out passes through CALC with a zero count, so it exits at once.
        ST_PREP: next_state = ST_CALC;
        ST_CALC: begin
          if (count == {CW{1'b0}}) begin
            next_state = ST_FIXUP;
          end else begin
            next_state = ST_CALC;
          end
        end
        ST_FIXUP: next_state = ST_DONE;
        ST_DONE: begin
          if (bus.in_result_ready) begin
            next_state = ST_IDLE;
          end else begin
            next_state = ST_DONE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3  <= 3'b000;
      op_a    <= {XLEN{1'b0}};
      op_b    <= {XLEN{1'b0}};
      res_neg <= 1'b0;
      acc     <= {AW{1'b0}};
      count   <= {CW{1'b0}};
      result  <= {XLEN{1'b0}};
    end else if (bus.in_flush) begin
      result  <= {XLEN{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            funct3 <= bus.in_funct3;
            op_a   <= bus.in_rs1;
            op_b   <= bus.in_rs2;
          end
        end
        ST_PREP: begin
          op_b    <= abs_b;
          res_neg <= sign_next;
          if (early_out) begin
            acc   <= {AW{1'b0}};
            count <= {CW{1'b0}};
          end else begin
            acc   <= {{(XLEN+1){1'b0}}, abs_a};
            count <= CW'(XLEN);
          end
        end
        ST_CALC: begin
          if (count != {CW{1'b0}}) begin
            acc   <= is_div ? div_next : mul_next;
            count <= count - CW'(1);
          end
        end
        ST_FIXUP: result <= fix_result;
        default: result <= result;
      endcase
    end
  end

  assign bus.out_ready  = (state == ST_IDLE);
  assign bus.out_busy   = (state != ST_IDLE);
  assign bus.out_valid  = (state == ST_DONE);
  assign bus.out_result = result;
endmodule
